// File: rtl/mul_div_unit_pkg.sv
// Shared types and latency helpers for the multiply/divide unit.
// Holds the operation encoding, the FSM state encoding and the functions
// that derive cycle counts and counter widths from the block parameters.
package mul_div_unit_pkg;

  typedef enum logic [3:0] {
    MD_NONE,
    MD_MULT,
    MD_MULTU,
    MD_MADD,
    MD_MADDU,
    MD_MSUB,
    MD_MSUBU,
    MD_DIV,
    MD_DIVU,
    MD_MTHI,
    MD_MTLO
  } md_func_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_DONE
  } md_state_t;

  function automatic logic is_mul_func(input md_func_t f);
    return f inside {MD_MULT, MD_MULTU, MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU};
  endfunction

  function automatic logic is_div_func(input md_func_t f);
    return f inside {MD_DIV, MD_DIVU};
  endfunction

  function automatic logic is_signed_func(input md_func_t f);
    return f inside {MD_MULT, MD_MADD, MD_MSUB, MD_DIV};
  endfunction

  // Cycles spent in the DIV state: one per DIV_BITS quotient bits plus the
  // sign-fixup cycle in which the result is committed.
  function automatic int div_cycles(input int width, input int div_bits);
    return width / div_bits + 1;
  endfunction

  // Cycles spent in the MUL state.
  function automatic int mul_cycles(input int lat);
    return lat;
  endfunction

  // Width of a counter that must hold values 0..n-1 (at least one bit).
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/div_iter.sv
// Iterative restoring divider on operand magnitudes, DIV_BITS quotient bits per cycle.
// Latency: start edge loads, WIDTH/DIV_BITS iteration cycles, then one fixup cycle with done high.
// Backpressure: none; abort drops the operation, done is a single-cycle result-valid strobe.
// Ports: clk/rst, start (load operands), abort, is_signed, dividend, divisor,
//        done, quotient, remainder (sign-corrected, valid while done is high).
module div_iter
  import mul_div_unit_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int DIV_BITS = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int ITER = div_cycles(WIDTH, DIV_BITS) - 1;
  localparam int CW   = cnt_width(ITER + 1);

  logic             busy;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] dvd_raw;
  logic             neg_q;
  logic             neg_r;
  logic             dvz;

  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] quo_nxt;
  logic [WIDTH-1:0] rem_nxt;
  logic [WIDTH:0]   sh;
  logic [WIDTH:0]   diff;

  always_comb begin
    a_mag = (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
    b_mag = (is_signed && divisor[WIDTH-1])  ? -divisor  : divisor;
  end

  // DIV_BITS restoring steps chained combinationally. The dividend is
  // shifted out of the top of quo while quotient bits enter at the bottom.
  // A set bit WIDTH of diff is the borrow: the trial subtract failed.
  always_comb begin
    quo_nxt = quo;
    rem_nxt = rem;
    sh      = '0;
    diff    = '0;
    for (int j = 0; j < DIV_BITS; j++) begin
      sh      = {rem_nxt, quo_nxt[WIDTH-1]};
      diff    = sh - {1'b0, dvs};
      quo_nxt = {quo_nxt[WIDTH-2:0], ~diff[WIDTH]};
      rem_nxt = diff[WIDTH] ? sh[WIDTH-1:0] : diff[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy    <= 1'b0;
      cnt     <= '0;
      quo     <= '0;
      rem     <= '0;
      dvs     <= '0;
      dvd_raw <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      dvz     <= 1'b0;
    end else if (abort) begin
      busy <= 1'b0;
    end else if (start) begin
      busy    <= 1'b1;
      cnt     <= '0;
      quo     <= a_mag;
      rem     <= '0;
      dvs     <= b_mag;
      dvd_raw <= dividend;
      neg_q   <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
      neg_r   <= is_signed & dividend[WIDTH-1];
      dvz     <= (divisor == '0);
    end else if (busy) begin
      if (cnt == CW'(ITER)) begin
        busy <= 1'b0;
      end else begin
        quo <= quo_nxt;
        rem <= rem_nxt;
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Fixup cycle: restore signs from the magnitudes. Divide-by-zero still
  // runs the full iteration count but reports all-ones and the raw dividend.
  // Most-negative / -1 falls out naturally: 2^(W-1) negated wraps to itself.
  always_comb begin
    done      = busy && (cnt == CW'(ITER));
    quotient  = dvz ? '1      : (neg_q ? -quo : quo);
    remainder = dvz ? dvd_raw : (neg_r ? -rem : rem);
  end

endmodule

// File: rtl/mul_div_unit.sv
// HI/LO multiply-divide unit: MUL/MADD/MSUB via a MUL_LAT pipeline, DIV via div_iter, MTHI/MTLO direct.
// Latency: MUL_LAT cycles in MUL, WIDTH/DIV_BITS+1 cycles in DIV after the acceptance edge; MTHI/MTLO next edge.
// Backpressure: alu_stall holds EX from acceptance until DONE; DONE waits out reg_stall so a func is not re-issued.
// Ports: clk, rst (async, active high), reg_stall, reg_flush, func, source_a, source_b,
//        alu_stall, hi, lo.
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int DIV_BITS = 1,
  parameter int MUL_LAT  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             reg_stall,
  input  logic             reg_flush,
  input  md_func_t         func,
  input  logic [WIDTH-1:0] source_a,
  input  logic [WIDTH-1:0] source_b,
  output logic             alu_stall,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int W2       = 2 * WIDTH;
  localparam int MUL_TERM = mul_cycles(MUL_LAT) - 1;
  localparam int MCW      = cnt_width(MUL_LAT);
  localparam int PIPE_N   = (MUL_LAT > 1) ? MUL_LAT - 1 : 1;

  md_state_t        state;
  md_state_t        state_nxt;
  md_func_t         op_func;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [MCW-1:0]   mul_cnt;

  logic accept_mul;
  logic accept_div;
  logic write_hi;
  logic write_lo;
  logic mul_commit;
  logic div_commit;
  logic div_abort;

  logic             div_done;
  logic [WIDTH-1:0] div_quo;
  logic [WIDTH-1:0] div_rem;

  logic             mul_signed;
  logic [W2-1:0]    ext_a;
  logic [W2-1:0]    ext_b;
  logic [W2-1:0]    prod_comb;
  logic [W2-1:0]    prod_q [PIPE_N];
  logic [W2-1:0]    prod_out;
  logic [W2-1:0]    mul_result;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    alu_stall  = 1'b0;
    accept_mul = 1'b0;
    accept_div = 1'b0;
    write_hi   = 1'b0;
    write_lo   = 1'b0;
    mul_commit = 1'b0;
    div_commit = 1'b0;
    div_abort  = 1'b0;
    case (state)
      S_IDLE: begin
        // A flushed EX instruction must not start or write anything, and
        // nothing is accepted (or stalled) while reset is held.
        if (!rst && !reg_flush) begin
          if (is_mul_func(func)) begin
            accept_mul = 1'b1;
            alu_stall  = 1'b1;
            state_nxt  = S_MUL;
          end else if (is_div_func(func)) begin
            accept_div = 1'b1;
            alu_stall  = 1'b1;
            state_nxt  = S_DIV;
          end else if (func == MD_MTHI) begin
            write_hi = 1'b1;
          end else if (func == MD_MTLO) begin
            write_lo = 1'b1;
          end
        end
      end
      S_MUL: begin
        if (reg_flush) begin
          state_nxt = S_IDLE;
        end else begin
          alu_stall = 1'b1;
          if (mul_cnt == MCW'(MUL_TERM)) begin
            mul_commit = 1'b1;
            state_nxt  = S_DONE;
          end
        end
      end
      S_DIV: begin
        if (reg_flush) begin
          div_abort = 1'b1;
          state_nxt = S_IDLE;
        end else begin
          alu_stall = 1'b1;
          if (div_done) begin
            div_commit = 1'b1;
            state_nxt  = S_DONE;
          end
        end
      end
      S_DONE: begin
        // EX advances on this cycle's edge only if the pipe is not stalled;
        // leaving DONE any earlier would see the same func again in IDLE.
        if (reg_flush || !reg_stall) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // ----------------------------------------------------- operand capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_a    <= '0;
      op_b    <= '0;
      op_func <= MD_NONE;
      mul_cnt <= '0;
    end else begin
      if (accept_mul || accept_div) begin
        op_a    <= source_a;
        op_b    <= source_b;
        op_func <= func;
      end
      if (accept_mul)           mul_cnt <= '0;
      else if (state == S_MUL)  mul_cnt <= mul_cnt + 1'b1;
    end
  end

  // ---------------------------------------------------------- multiplier
  // Operand registers form the first stage; MUL_LAT-1 product registers
  // follow, so the last MUL cycle sees a fully settled product.
  always_comb begin
    mul_signed = is_signed_func(op_func);
    ext_a      = mul_signed ? {{WIDTH{op_a[WIDTH-1]}}, op_a} : {{WIDTH{1'b0}}, op_a};
    ext_b      = mul_signed ? {{WIDTH{op_b[WIDTH-1]}}, op_b} : {{WIDTH{1'b0}}, op_b};
    // The low 2*WIDTH bits of the extended product are right for both signednesses.
    prod_comb  = ext_a * ext_b;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < PIPE_N; k++) prod_q[k] <= '0;
    end else begin
      prod_q[0] <= prod_comb;
      for (int k = 1; k < PIPE_N; k++) prod_q[k] <= prod_q[k-1];
    end
  end

  generate
    if (MUL_LAT == 1) begin : g_mul_comb
      assign prod_out = prod_comb;
    end else begin : g_mul_pipe
      assign prod_out = prod_q[MUL_LAT-2];
    end
  endgenerate

  // HI/LO cannot change while the unit is busy, so the live registers equal
  // the accumulator value as it stood at acceptance.
  always_comb begin
    case (op_func)
      MD_MADD, MD_MADDU: mul_result = {hi, lo} + prod_out;
      MD_MSUB, MD_MSUBU: mul_result = {hi, lo} - prod_out;
      default:           mul_result = prod_out;
    endcase
  end

  // ------------------------------------------------------------- divider
  div_iter #(
    .WIDTH    (WIDTH),
    .DIV_BITS (DIV_BITS)
  ) u_div_iter (
    .clk       (clk),
    .rst       (rst),
    .start     (accept_div),
    .abort     (div_abort),
    .is_signed (is_signed_func(func)),
    .dividend  (source_a),
    .divisor   (source_b),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  // -------------------------------------------------------------- HI/LO
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi <= '0;
      lo <= '0;
    end else if (mul_commit) begin
      {hi, lo} <= mul_result;
    end else if (div_commit) begin
      hi <= div_rem;
      lo <= div_quo;
    end else begin
      if (write_hi) hi <= source_a;
      if (write_lo) lo <= source_a;
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: one 32-bit/radix-2 and one 64-bit/radix-16 instance,
// stimulus routed to the selected instance while the other sees MD_NONE.
// Stall counts are cycles with alu_stall high after the acceptance edge.
module tb_mul_div_unit;
  import mul_div_unit_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, reg_stall, reg_flush;
  md_func_t    func, func32, func64;
  logic [63:0] src_a, src_b;
  bit          sel64;

  logic        stall32, stall64;
  logic [31:0] hi32, lo32;
  logic [63:0] hi64, lo64;
  logic        cur_stall;
  logic [63:0] cur_hi, cur_lo;

  int n_checks = 0;
  int n_fail   = 0;

  assign func32    = sel64 ? MD_NONE : func;
  assign func64    = sel64 ? func : MD_NONE;
  assign cur_stall = sel64 ? stall64 : stall32;
  assign cur_hi    = sel64 ? hi64 : {32'h0, hi32};
  assign cur_lo    = sel64 ? lo64 : {32'h0, lo32};

  mul_div_unit #(.WIDTH(32), .DIV_BITS(1), .MUL_LAT(2)) dut32 (
    .clk(clk), .rst(rst), .reg_stall(reg_stall), .reg_flush(reg_flush), .func(func32),
    .source_a(src_a[31:0]), .source_b(src_b[31:0]), .alu_stall(stall32), .hi(hi32), .lo(lo32));

  mul_div_unit #(.WIDTH(64), .DIV_BITS(4), .MUL_LAT(2)) dut64 (
    .clk(clk), .rst(rst), .reg_stall(reg_stall), .reg_flush(reg_flush), .func(func64),
    .source_a(src_a), .source_b(src_b), .alu_stall(stall64), .hi(hi64), .lo(lo64));

  function automatic logic [63:0] msk(input logic [63:0] x);
    return sel64 ? x : {32'h0, x[31:0]};
  endfunction

  function automatic int wid();
    return sel64 ? 64 : 32;
  endfunction

  function automatic int div_lat();
    return sel64 ? 17 : 33;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; cyc(); cyc(); rst = 1'b0;
  endtask

  task automatic set_hilo(input logic [63:0] h, input logic [63:0] l);
    func = MD_MTHI; src_a = h; cyc();
    func = MD_MTLO; src_a = l; cyc();
    func = MD_NONE; src_a = '0;
  endtask

  // Issue one op with reg_stall low, count busy cycles (bounded), leave unit in IDLE.
  task automatic run_op(input md_func_t f, input logic [63:0] a, input logic [63:0] b,
                        output logic acc_stall, output int n_stall);
    func = f; src_a = a; src_b = b;
    @(negedge clk); acc_stall = cur_stall;
    cyc();
    n_stall = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!cur_stall) break;
      n_stall++;
      cyc();
    end
    cyc();
    func = MD_NONE; src_a = '0; src_b = '0;
  endtask

  task automatic test_reset();
    n_checks++; if (hi32 !== 32'h0 || lo32 !== 32'h0) begin n_fail++; $display("FAIL reset_hilo32: got %h/%h want 0/0", hi32, lo32); end
    n_checks++; if (hi64 !== 64'h0 || lo64 !== 64'h0) begin n_fail++; $display("FAIL reset_hilo64: got %h/%h want 0/0", hi64, lo64); end
    n_checks++; if (stall32 !== 1'b0 || stall64 !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b/%b want 0/0", stall32, stall64); end
  endtask

  task automatic test_mthi_mtlo();
    func = MD_MTHI; src_a = 64'h0123_4567_89ab_cdef;
    @(negedge clk);
    n_checks++; if (cur_stall !== 1'b0) begin n_fail++; $display("FAIL mthi_stall w%0d: got %b want 0", wid(), cur_stall); end
    cyc();
    n_checks++; if (cur_hi !== msk(64'h0123_4567_89ab_cdef) || cur_lo !== 64'h0) begin n_fail++; $display("FAIL mthi w%0d: got %h/%h want %h/0", wid(), cur_hi, cur_lo, msk(64'h0123_4567_89ab_cdef)); end
    func = MD_MTLO; src_a = 64'hfedc_ba98_7654_3210;
    cyc();
    func = MD_NONE;
    n_checks++; if (cur_lo !== msk(64'hfedc_ba98_7654_3210) || cur_hi !== msk(64'h0123_4567_89ab_cdef)) begin n_fail++; $display("FAIL mtlo w%0d: got %h/%h", wid(), cur_hi, cur_lo); end
  endtask

  task automatic test_mult();
    logic acc; int n;
    run_op(MD_MULT, '1, 64'd2, acc, n);
    n_checks++; if (acc !== 1'b1) begin n_fail++; $display("FAIL mult_accept_stall w%0d: got %b want 1", wid(), acc); end
    n_checks++; if (n !== 2) begin n_fail++; $display("FAIL mult_stall_cycles w%0d: got %0d want 2", wid(), n); end
    n_checks++; if (cur_hi !== msk('1) || cur_lo !== msk(64'hffff_ffff_ffff_fffe)) begin n_fail++; $display("FAIL mult w%0d: got %h/%h", wid(), cur_hi, cur_lo); end
    run_op(MD_MULTU, '1, 64'd2, acc, n);
    n_checks++; if (cur_hi !== 64'h1 || cur_lo !== msk(64'hffff_ffff_ffff_fffe)) begin n_fail++; $display("FAIL multu w%0d: got %h/%h want 1/..fe", wid(), cur_hi, cur_lo); end
  endtask

  task automatic test_madd();
    logic acc; int n;
    set_hilo(64'h0, '1);
    run_op(MD_MADDU, 64'd1, 64'd1, acc, n);
    n_checks++; if (cur_hi !== 64'h1 || cur_lo !== 64'h0) begin n_fail++; $display("FAIL maddu_carry w%0d: got %h/%h want 1/0", wid(), cur_hi, cur_lo); end
    set_hilo(64'h0, 64'h0);
    run_op(MD_MADD, '1, 64'd1, acc, n);
    n_checks++; if (cur_hi !== msk('1) || cur_lo !== msk('1)) begin n_fail++; $display("FAIL madd_neg w%0d: got %h/%h want all ones", wid(), cur_hi, cur_lo); end
  endtask

  task automatic test_msubu();
    logic acc; int n;
    set_hilo(64'h0, 64'd10);
    run_op(MD_MSUBU, 64'd3, 64'd5, acc, n);
    n_checks++; if (cur_hi !== msk('1) || cur_lo !== msk(64'hffff_ffff_ffff_fffb)) begin n_fail++; $display("FAIL msubu w%0d: got %h/%h", wid(), cur_hi, cur_lo); end
  endtask

  task automatic test_div();
    logic acc; int n;
    run_op(MD_DIV, 64'hffff_ffff_ffff_fff9, 64'd2, acc, n);
    n_checks++; if (acc !== 1'b1) begin n_fail++; $display("FAIL div_accept_stall w%0d: got %b want 1", wid(), acc); end
    n_checks++; if (n !== div_lat()) begin n_fail++; $display("FAIL div_stall_cycles w%0d: got %0d want %0d", wid(), n, div_lat()); end
    n_checks++; if (cur_lo !== msk(64'hffff_ffff_ffff_fffd) || cur_hi !== msk('1)) begin n_fail++; $display("FAIL div_m7_2 w%0d: got hi %h lo %h", wid(), cur_hi, cur_lo); end
    run_op(MD_DIV, 64'd7, 64'hffff_ffff_ffff_fffe, acc, n);
    n_checks++; if (cur_lo !== msk(64'hffff_ffff_ffff_fffd) || cur_hi !== 64'd1) begin n_fail++; $display("FAIL div_7_m2 w%0d: got hi %h lo %h", wid(), cur_hi, cur_lo); end
    run_op(MD_DIVU, 64'd100, 64'd7, acc, n);
    n_checks++; if (cur_lo !== 64'd14 || cur_hi !== 64'd2) begin n_fail++; $display("FAIL divu_100_7 w%0d: got hi %h lo %h", wid(), cur_hi, cur_lo); end
    run_op(MD_DIVU, '1, 64'd3, acc, n);
    n_checks++; if (cur_lo !== msk(64'h5555_5555_5555_5555) || cur_hi !== 64'd0) begin n_fail++; $display("FAIL divu_max_3 w%0d: got hi %h lo %h", wid(), cur_hi, cur_lo); end
  endtask

  task automatic test_div_special();
    logic acc; int n;
    logic [63:0] most_neg;
    most_neg = sel64 ? 64'h8000_0000_0000_0000 : 64'h0000_0000_8000_0000;
    run_op(MD_DIV, most_neg, '1, acc, n);
    n_checks++; if (cur_lo !== most_neg || cur_hi !== 64'd0) begin n_fail++; $display("FAIL div_ovf w%0d: got hi %h lo %h", wid(), cur_hi, cur_lo); end
    run_op(MD_DIVU, 64'd5, 64'd0, acc, n);
    n_checks++; if (n !== div_lat()) begin n_fail++; $display("FAIL divz_stall_cycles w%0d: got %0d want %0d", wid(), n, div_lat()); end
    n_checks++; if (cur_lo !== msk('1) || cur_hi !== 64'd5) begin n_fail++; $display("FAIL divu_5_0 w%0d: got hi %h lo %h", wid(), cur_hi, cur_lo); end
    run_op(MD_DIV, 64'hffff_ffff_ffff_fffb, 64'd0, acc, n);
    n_checks++; if (cur_lo !== msk('1) || cur_hi !== msk(64'hffff_ffff_ffff_fffb)) begin n_fail++; $display("FAIL div_m5_0 w%0d: got hi %h lo %h", wid(), cur_hi, cur_lo); end
  endtask

  task automatic test_flush();
    set_hilo(64'h11, 64'h22);
    func = MD_DIVU; src_a = 64'd100; src_b = 64'd7;
    @(negedge clk);
    cyc();
    repeat (9) cyc();
    reg_flush = 1'b1; func = MD_NONE;
    cyc();
    reg_flush = 1'b0;
    @(negedge clk);
    n_checks++; if (cur_stall !== 1'b0) begin n_fail++; $display("FAIL div_flush_stall w%0d: got %b want 0", wid(), cur_stall); end
    n_checks++; if (cur_hi !== 64'h11 || cur_lo !== 64'h22) begin n_fail++; $display("FAIL div_flush_hilo w%0d: got %h/%h want 11/22", wid(), cur_hi, cur_lo); end
    repeat (40) cyc();
    n_checks++; if (cur_hi !== 64'h11 || cur_lo !== 64'h22) begin n_fail++; $display("FAIL div_flush_late w%0d: got %h/%h want 11/22", wid(), cur_hi, cur_lo); end
    func = MD_MULT; src_a = 64'd3; src_b = 64'd5;
    cyc();
    reg_flush = 1'b1; func = MD_NONE;
    cyc();
    reg_flush = 1'b0;
    repeat (4) cyc();
    n_checks++; if (cur_stall !== 1'b0 || cur_hi !== 64'h11 || cur_lo !== 64'h22) begin n_fail++; $display("FAIL mul_flush w%0d: got stall %b hilo %h/%h", wid(), cur_stall, cur_hi, cur_lo); end
  endtask

  task automatic test_rst_mid();
    set_hilo(64'h55, 64'h66);
    func = MD_MULT; src_a = 64'd3; src_b = 64'd5;
    cyc();
    #2 rst = 1'b1; func = MD_NONE;
    #1;
    n_checks++; if (cur_hi !== 64'h0 || cur_lo !== 64'h0 || cur_stall !== 1'b0) begin n_fail++; $display("FAIL rst_async w%0d: got stall %b hilo %h/%h", wid(), cur_stall, cur_hi, cur_lo); end
    cyc();
    rst = 1'b0;
    repeat (4) cyc();
    n_checks++; if (cur_hi !== 64'h0 || cur_lo !== 64'h0 || cur_stall !== 1'b0) begin n_fail++; $display("FAIL rst_no_late_write w%0d: got stall %b hilo %h/%h", wid(), cur_stall, cur_hi, cur_lo); end
  endtask

  task automatic test_done_hold();
    int n;
    for (int v = 0; v < 2; v++) begin
      if (v == 1) set_hilo(64'h0, 64'd10);
      reg_stall = 1'b1;
      func = (v == 1) ? MD_MADDU : MD_MULTU; src_a = 64'd2; src_b = 64'd3;
      @(negedge clk);
      cyc();
      n = 0;
      for (int i = 0; i < 50; i++) begin
        @(negedge clk);
        if (!cur_stall) break;
        n++;
        cyc();
      end
      n_checks++; if (n !== 2) begin n_fail++; $display("FAIL hold_stall_cycles w%0d v%0d: got %0d want 2", wid(), v, n); end
      for (int k = 0; k < 3; k++) begin
        if (k > 0) begin cyc(); @(negedge clk); end
        n_checks++; if (cur_stall !== 1'b0) begin n_fail++; $display("FAIL hold_stall w%0d v%0d c%0d: got %b want 0", wid(), v, k, cur_stall); end
        n_checks++; if (cur_lo !== ((v == 1) ? 64'd16 : 64'd6)) begin n_fail++; $display("FAIL hold_lo w%0d v%0d c%0d: got %h", wid(), v, k, cur_lo); end
      end
      reg_stall = 1'b0;
      cyc();
      func = MD_NONE;
      @(negedge clk);
      n_checks++; if (cur_stall !== 1'b0 || cur_hi !== 64'h0 || cur_lo !== ((v == 1) ? 64'd16 : 64'd6)) begin n_fail++; $display("FAIL hold_single_commit w%0d v%0d: got stall %b hilo %h/%h", wid(), v, cur_stall, cur_hi, cur_lo); end
      cyc();
    end
  endtask

  initial begin
    rst = 1'b0; reg_stall = 1'b0; reg_flush = 1'b0;
    func = MD_NONE; src_a = '0; src_b = '0; sel64 = 1'b0;
    #1 rst = 1'b1;
    #1 test_reset();
    cyc();
    rst = 1'b0;
    for (int s = 0; s < 2; s++) begin
      sel64 = (s == 1);
      do_reset();
      test_mthi_mtlo();
      test_mult();
      test_madd();
      test_msubu();
      test_div();
      test_div_special();
      test_flush();
      test_rst_mid();
      test_done_hold();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand, HI and LO width; legal values 16, 32, 64.
REQ-002 SHALL have parameter DIV_BITS, default 1: quotient bits retired per divide cycle; legal values 1, 2, 4; WIDTH divisible by DIV_BITS.
REQ-003 SHALL have parameter MUL_LAT, default 2: multiply latency in cycles; legal range 1..4.
REQ-004 SHALL have one clock and an asynchronous, active-high reset.
REQ-005 clk  in  1  clock, all state on the rising edge.
REQ-006 rst  in  1  asynchronous active-high reset.
REQ-007 reg_stall  in  1  downstream pipeline stall.
REQ-008 reg_flush  in  1  EX-stage flush, aborts any operation.
REQ-009 func  in  md_func_t  operation: NONE, MULT, MULTU, MADD, MADDU, MSUB, MSUBU, DIV, DIVU, MTHI, MTLO.
REQ-010 source_a  in  WIDTH  rs operand, and MTHI/MTLO data.
REQ-011 source_b  in  WIDTH  rt operand.
REQ-012 alu_stall  out  1  unit busy; EX holds func and operands.
REQ-013 hi  out  WIDTH  architectural HI.
REQ-014 lo  out  WIDTH  architectural LO.

Function
REQ-015 FSM states SHALL be IDLE, MUL, DIV, DONE.
REQ-016 IDLE with MTHI/MTLO SHALL write source_a to hi/lo at the next edge with no stall and no state change.
REQ-017 IDLE with a MUL-class func and reg_flush low SHALL latch the operands, go to MUL, and drive alu_stall high combinationally in that same cycle.
REQ-018 IDLE with DIV/DIVU and reg_flush low SHALL latch the operands, go to DIV, and drive alu_stall high combinationally in that same cycle.
REQ-019 In MUL, the unit SHALL hold alu_stall high and count MUL_LAT cycles, then commit the 2*WIDTH product to {hi,lo} and enter DONE.
REQ-020 For MADD/MSUB, {hi,lo} SHALL become {hi,lo} ± product, modulo 2^(2*WIDTH); the value used is HI/LO as sampled at acceptance.
REQ-021 DIV SHALL be a restoring or non-restoring iterative divide on magnitudes, running WIDTH/DIV_BITS cycles plus one sign-fixup cycle, then committing lo=quotient and hi=remainder and entering DONE.
REQ-022 Quotient SHALL truncate toward zero, and the remainder sign SHALL equal the dividend sign.
REQ-023 Divide by zero SHALL commit lo=all-ones and hi=dividend, and SHALL take the full latency.
REQ-024 Signed most-negative/-1 SHALL commit lo=most-negative and hi=0.
REQ-025 In DONE, alu_stall SHALL be low so EX can advance.
REQ-026 In DONE, the unit SHALL stay in DONE while reg_stall is high and SHALL go to IDLE when reg_stall is low, so the same func is never re-issued.
REQ-027 reg_flush high in MUL or DIV SHALL return the unit to IDLE next cycle with hi/lo unchanged and alu_stall low.
REQ-028 reg_flush in DONE SHALL go to IDLE; the committed result stands.
REQ-029 hi and lo SHALL change only at a commit or an MTHI/MTLO edge, never mid-operation.

Reset
REQ-030 rst SHALL force state=IDLE, hi=0, lo=0, alu_stall=0, and clear all counters and operand registers, regardless of the clock.
REQ-031 rst asserted mid-operation SHALL discard the operation, with no partial HI/LO write after release.

Structure
REQ-032 md_func_t, the FSM state enum and the latency-derivation functions SHALL live in the shared includes package.
REQ-033 The divider datapath SHALL be the single sub-module div_iter, parameterised by WIDTH and DIV_BITS, with a start/done handshake.
REQ-034 The multiplier SHALL be an inline MUL_LAT-deep register pipeline.

Verification
REQ-035 WIDTH=32, MUL_LAT=2, MULT 0xFFFFFFFF x 0x00000002 -> alu_stall high for 2 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFE.
REQ-036 Start hi=0, lo=10; MSUBU 3 x 5 -> hi=0xFFFFFFFF, lo=0xFFFFFFFB.
REQ-037 DIV -7/2 with DIV_BITS=1 -> 33 stall cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-038 DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0; DIVU 5/0 -> lo=0xFFFFFFFF, hi=5.
REQ-039 Issue DIVU; assert reg_flush on cycle 10 -> alu_stall low next cycle, hi/lo unchanged; assert rst mid-MULT -> hi=lo=0, state IDLE.
REQ-040 Hold reg_stall high 3 cycles in DONE after MULTU 2x3 -> lo=6, single commit only; repeat all scenarios at WIDTH=64, DIV_BITS=4.
